change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 55 +++++
 tb/tb_change_dispenser.sv | 121 ++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin change dispenser with a ready/valid hopper handshake.
module change_dispenser #(
  parameter int COIN0 = 50,
  parameter int COIN1 = 10,
  parameter int COIN2 = 5,
  parameter int COIN3 = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] changeAmount,
  input  logic       coinReady,
  output logic       coinValid,
  output logic [1:0] coinType,
  output logic       busy,
  output logic       done,
  output logic [3:0] coinCount,
  output logic [6:0] paidOut
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic [6:0] C0 = 7'(COIN0);
  localparam logic [6:0] C1 = 7'(COIN1);
  localparam logic [6:0] C2 = 7'(COIN2);
  localparam logic [6:0] C3 = 7'(COIN3);
  state_t state, state_n;
  logic [6:0] remaining, coin;
  // Coin choice depends only on the remaining register, so outputs never see inputs.
  always_comb begin
    coinType = remaining >= C0 ? 2'd0 : remaining >= C1 ? 2'd1 : remaining >= C2 ? 2'd2 : 2'd3;
    coin = remaining >= C0 ? C0 : remaining >= C1 ? C1 : remaining >= C2 ? C2 : C3;
    coinValid = state == ISSUE;
    busy = state == ISSUE;
    done = state == DONE;
    state_n = state == IDLE ? (start ? (changeAmount != 7'd0 ? ISSUE : DONE) : IDLE)
            : state == ISSUE ? (coinReady && remaining == coin ? DONE : ISSUE)
            : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      coinCount <= '0;
      paidOut <= '0;
    end else if (state == IDLE && start) begin
      remaining <= changeAmount;
      coinCount <= '0;
      paidOut <= '0;
    end else if (state == ISSUE && coinReady) begin
      remaining <= remaining - coin;
      coinCount <= coinCount + {3'b0, coinCount != 4'hf};
      paidOut <= paidOut + coin;
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized check of change_dispenser against a greedy-change reference model.
module tb_change_dispenser;
  logic clk = 0, reset = 1, start = 0, coinReady = 0;
  logic [6:0] changeAmount = '0;
  logic coinValid, busy, done;
  logic [1:0] coinType;
  logic [3:0] coinCount;
  logic [6:0] paidOut;
  int nchk = 0, nerr = 0;
  int vals[4] = '{50, 10, 5, 1};
  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .changeAmount(changeAmount),
    .coinReady(coinReady), .coinValid(coinValid), .coinType(coinType),
    .busy(busy), .done(done), .coinCount(coinCount), .paidOut(paidOut)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run(int amt, int pct, int stall, bit poke);
    int q[$];
    int r = amt, acc = 0, n = 0, cyc = 0, issue = 0, stalls = 0, ncoins;
    for (int k = 0; k < 4; k++) begin
      repeat (r / vals[k]) q.push_back(k);
      r = r % vals[k];
    end
    ncoins = q.size();
    coinReady = 0;
    start = 1;
    changeAmount = 7'(amt);
    step();
    start = 0;
    while (!done && cyc < 300) begin
      chk("valid", coinValid, 1);
      chk("busy", busy, 1);
      chk("type", coinType, q.size() != 0 ? q[0] : 9);
      chk("paid_run", paidOut, acc);
      chk("count_run", coinCount, n);
      issue++;
      if (stall > 0) begin
        coinReady = 0;
        stall--;
      end else coinReady = $urandom_range(99) < pct;
      if (!coinReady) stalls++;
      start = poke && $urandom_range(3) == 0;
      changeAmount = 7'($urandom);
      step();
      cyc++;
      if (coinReady && q.size() != 0) begin
        acc += vals[q[0]];
        n++;
        void'(q.pop_front());
      end
    end
    start = 0;
    coinReady = 0;
    chk("done_seen", done, 1);
    chk("done_valid", coinValid, 0);
    chk("done_busy", busy, 0);
    chk("coins_left", q.size(), 0);
    chk("count", coinCount, ncoins > 15 ? 15 : ncoins);
    chk("paid", paidOut, amt);
    chk("issue_cycles", issue, ncoins + stalls);
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_paid", paidOut, amt);
    chk("idle_count", coinCount, ncoins > 15 ? 15 : ncoins);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", coinValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", coinCount, 0);
    chk("rst_paid", paidOut, 0);
    reset = 0;
    step();
    run(37, 100, 0, 0);
    run(0, 100, 0, 0);
    run(127, 100, 0, 0);
    run(15, 100, 3, 0);
    run(60, 100, 0, 1);
    start = 1;
    changeAmount = 7'd37;
    coinReady = 1;
    step();
    start = 0;
    chk("mid_type0", coinType, 1);
    step();
    chk("mid_paid", paidOut, 10);
    reset = 1;
    start = 1;
    step();
    chk("mid_valid", coinValid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_count", coinCount, 0);
    chk("mid_paid0", paidOut, 0);
    reset = 0;
    start = 0;
    coinReady = 0;
    step();
    chk("mid_nodone", done, 0);
    chk("mid_idle", coinValid, 0);
    run(6, 100, 0, 0);
    for (int a = 0; a < 128; a++) run(a, 70, $urandom_range(2), 1);
    repeat (40) run($urandom_range(127), $urandom_range(30, 100), 0, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
